branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Dynamic branch-direction predictor and flush controller for the RV32I core.
- Holds a table of 2-bit saturating counters indexed by PC and supplies a taken/not-taken prediction to fetch.
- Trains each counter from the resolved branch outcome, which is the BranchCondition produced by branch control.
- Raises a one-cycle Flush pulse on a misprediction, and runs a table-clear sequence on request.

Parameters:
- IndexBits, 6, log2 of table entries; Entries = 2**IndexBits.
- XLEN, 32, PC width.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high.
- FetchValid  input  1  a lookup is requested this cycle.
- FetchPC  input  XLEN  PC of the instruction being looked up.
- PredValid  output  1  PredictTaken is valid; registered.
- PredictTaken  output  1  predicted direction; registered.
- ResolveValid  input  1  a conditional branch resolved this cycle.
- ResolvePC  input  XLEN  PC of the resolved branch.
- ResolveTaken  input  1  actual outcome (BranchCondition).
- ResolvePredicted  input  1  the prediction that was used for this branch.
- Flush  output  1  misprediction pulse; registered.
- ClearReq  input  1  request to reinitialise the table.
- Busy  output  1  high while the clear sequence runs.

Behaviour:
- Index function: idx = PC[IndexBits+1:2]; PC bits [1:0] are ignored.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- Reset (async): all counters = 01; PredValid = 0, PredictTaken = 0, Flush = 0, Busy = 0; FSM = IDLE.
- Lookup latency is 1 cycle:
  - PredValid(t+1) = FetchValid(t) in IDLE; it is 0 in CLEAR.
  - PredictTaken(t+1) = counter[idx(FetchPC)] sampled at t. When PredValid is 0, PredictTaken is 0.
- Update on ResolveValid in IDLE:
  - ResolveTaken = 1: counter increments, saturating at 11.
  - ResolveTaken = 0: counter decrements, saturating at 00.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value (read-before-write). The update still commits.
- Flush(t+1) = ResolveValid(t) & (ResolveTaken != ResolvePredicted). Flush is a one-cycle pulse and is not gated by FSM state.
- Back-to-back mispredicts produce back-to-back Flush pulses; no merging.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when ClearReq = 1. The clear pointer loads 0; Busy rises the next cycle.
  - CLEAR writes 01 into entry[ptr] each cycle, then ptr++.
  - CLEAR -> IDLE after writing entry Entries-1; Busy falls in the same cycle as the return to IDLE.
  - Clear duration is exactly Entries cycles of Busy = 1.
  - During CLEAR, updates are dropped, PredValid = 0, and ClearReq is ignored.
  - A ClearReq held high in IDLE after the sequence completes starts a new clear.
- Reset asserted mid-CLEAR aborts the sequence. All entries = 01 and the FSM returns to IDLE.
- Pointer width is IndexBits; wrap-around never occurs because the FSM exits at Entries-1.

Optional Feature:
- Macro: BRANCH_PREDICT_STATS_EN.
- Defined: adds output ports BranchCount (32) and MispredictCount (32).
  - BranchCount increments on each ResolveValid accepted in IDLE.
  - MispredictCount increments on each cycle that schedules a Flush pulse.
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared by reset and on the IDLE -> CLEAR transition.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then FetchValid = 1, FetchPC = 0x100 -> next cycle PredValid = 1, PredictTaken = 0 (entry 01).
- Two resolves of PC 0x100 with ResolveTaken = 1, then a lookup of 0x100 -> PredictTaken = 1 (counter 11). A third taken resolve keeps the counter at 11. One not-taken resolve leaves the prediction at 1 (10).
- ResolveValid = 1, ResolveTaken = 1, ResolvePredicted = 0 -> Flush = 1 for exactly one cycle, one cycle later. With matching inputs, Flush stays 0.
- Lookup and update of PC 0x104 in the same cycle, counter at 01, resolve taken -> PredictTaken = 0. A follow-up lookup returns 1.
- Train PC 0x200 to 11, pulse ClearReq for one cycle -> Busy is high for exactly 64 cycles with PredValid = 0. Resolves issued during Busy do not change the table. Afterwards, a lookup of 0x200 returns 0.
- Assert reset at clear cycle 10 -> Busy = 0 immediately and all entries read 01. With BRANCH_PREDICT_STATS_EN defined: 3 resolves including 1 mispredict -> BranchCount = 3, MispredictCount = 1.

Source files
------------

// File: rtl/branch_predict_ctrl_if.sv
// branch_predict_ctrl_if: fetch lookup, branch resolve, flush and clear signals of branch_predict_ctrl.
// BranchCount/MispredictCount exist only when BRANCH_PREDICT_STATS_EN is defined.
interface branch_predict_ctrl_if #(parameter int XLEN = 32);
  logic            FetchValid;
  logic [XLEN-1:0] FetchPC;
  logic            PredValid;
  logic            PredictTaken;
  logic            ResolveValid;
  logic [XLEN-1:0] ResolvePC;
  logic            ResolveTaken;
  logic            ResolvePredicted;
  logic            Flush;
  logic            ClearReq;
  logic            Busy;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0]     BranchCount;
  logic [31:0]     MispredictCount;
`endif
  modport master (
    output FetchValid, FetchPC, ResolveValid, ResolvePC, ResolveTaken, ResolvePredicted, ClearReq,
`ifdef BRANCH_PREDICT_STATS_EN
    input  BranchCount, MispredictCount,
`endif
    input  PredValid, PredictTaken, Flush, Busy
  );
  modport slave (
    input  FetchValid, FetchPC, ResolveValid, ResolvePC, ResolveTaken, ResolvePredicted, ClearReq,
`ifdef BRANCH_PREDICT_STATS_EN
    output BranchCount, MispredictCount,
`endif
    output PredValid, PredictTaken, Flush, Busy
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: 2-bit saturating-counter direction predictor with mispredict flush and table clear.
// Optional BRANCH_PREDICT_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_ctrl #(
  parameter int IndexBits = 6,
  parameter int XLEN      = 32
) (
  input logic clk,
  input logic reset,
  branch_predict_ctrl_if.slave bp
);
  localparam int Entries = 2 ** IndexBits;
  localparam logic [IndexBits-1:0] PtrLast = '1;
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e                      state_q;
  logic [Entries-1:0][1:0]     ctr_q;
  logic [IndexBits-1:0]        ptr_q;
  logic                        pred_valid_q, pred_taken_q, flush_q, busy_q;
  logic [IndexBits-1:0]        fetch_idx, resolve_idx;
  logic [1:0]                  ctr_cur, ctr_d;
  logic                        idle, mispredict;
  logic                        unused_pc;
  assign idle        = state_q == IDLE;
  assign fetch_idx   = bp.FetchPC[IndexBits+1:2];
  assign resolve_idx = bp.ResolvePC[IndexBits+1:2];
  assign mispredict  = bp.ResolveValid & (bp.ResolveTaken != bp.ResolvePredicted);
  assign unused_pc   = ^{bp.FetchPC[XLEN-1:IndexBits+2], bp.FetchPC[1:0],
                         bp.ResolvePC[XLEN-1:IndexBits+2], bp.ResolvePC[1:0]};
  always_comb begin
    ctr_cur = ctr_q[resolve_idx];
    ctr_d   = bp.ResolveTaken ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01)
                              : ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01);
  end
  // Lookup reads ctr_q before this edge's update, giving read-before-write on index collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q        <= {Entries{2'b01}};
      state_q      <= IDLE;
      ptr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pred_valid_q <= idle & bp.FetchValid;
      pred_taken_q <= idle & bp.FetchValid & ctr_q[fetch_idx][1];
      flush_q      <= mispredict;
      if (idle) begin
        if (bp.ResolveValid) ctr_q[resolve_idx] <= ctr_d;
        if (bp.ClearReq) begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
          ptr_q   <= '0;
        end
      end else begin
        ctr_q[ptr_q] <= 2'b01;
        ptr_q        <= ptr_q + 1'b1;
        if (ptr_q == PtrLast) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end
    end
  end
  assign bp.PredValid    = pred_valid_q;
  assign bp.PredictTaken = pred_taken_q;
  assign bp.Flush        = flush_q;
  assign bp.Busy         = busy_q;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (idle & bp.ClearReq) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (idle & bp.ResolveValid & (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict & (mispredict_cnt_q != '1)) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end
  assign bp.BranchCount     = branch_cnt_q;
  assign bp.MispredictCount = mispredict_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: scoreboard bench; a counter-array model predicts every cycle's outputs.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  branch_predict_ctrl_if #(.XLEN(32)) bp();
  branch_predict_ctrl #(.IndexBits(6), .XLEN(32)) dut (.clk(clk), .reset(reset), .bp(bp));
  typedef struct {
    logic pv, pt, fl, busy;
    int unsigned bc, mc;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int cnt[64];
  int clear_left;
  int unsigned m_bc, m_mc;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    clear_left = 0;
    m_bc = 0;
    m_mc = 0;
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("PredValid", {31'b0, bp.PredValid}, {31'b0, e_mon.pv});
      chk("PredictTaken", {31'b0, bp.PredictTaken}, {31'b0, e_mon.pt});
      chk("Flush", {31'b0, bp.Flush}, {31'b0, e_mon.fl});
      chk("Busy", {31'b0, bp.Busy}, {31'b0, e_mon.busy});
`ifdef BRANCH_PREDICT_STATS_EN
      chk("BranchCount", bp.BranchCount, e_mon.bc);
      chk("MispredictCount", bp.MispredictCount, e_mon.mc);
`endif
    end
  end
  task automatic step(input bit fv, input logic [31:0] pc, input bit rv, input logic [31:0] rpc,
                      input bit rt, input bit rp, input bit cr);
    exp_t e;
    int fi, ri;
    @(negedge clk);
    bp.FetchValid = fv;
    bp.FetchPC = pc;
    bp.ResolveValid = rv;
    bp.ResolvePC = rpc;
    bp.ResolveTaken = rt;
    bp.ResolvePredicted = rp;
    bp.ClearReq = cr;
    fi = int'((pc >> 2) % 64);
    ri = int'((rpc >> 2) % 64);
    e.pv = (clear_left == 0) && fv;
    e.pt = e.pv && (cnt[fi] >= 2);
    e.fl = rv && (rt != rp);
    if (rv && (rt != rp)) m_mc++;
    if (clear_left > 0) begin
      cnt[64 - clear_left] = 1;
      clear_left--;
    end else begin
      if (rv) begin
        m_bc++;
        cnt[ri] = rt ? ((cnt[ri] < 3) ? cnt[ri] + 1 : 3) : ((cnt[ri] > 0) ? cnt[ri] - 1 : 0);
      end
      if (cr) begin
        clear_left = 64;
        m_bc = 0;
        m_mc = 0;
      end
    end
    e.busy = clear_left > 0;
    e.bc = m_bc;
    e.mc = m_mc;
    q.push_back(e);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_PredValid"}, {31'b0, bp.PredValid}, 32'd0);
    chk({tag, "_PredictTaken"}, {31'b0, bp.PredictTaken}, 32'd0);
    chk({tag, "_Flush"}, {31'b0, bp.Flush}, 32'd0);
    chk({tag, "_Busy"}, {31'b0, bp.Busy}, 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] pc, rpc;
    bp.FetchValid = 0; bp.FetchPC = 0; bp.ResolveValid = 0; bp.ResolvePC = 0;
    bp.ResolveTaken = 0; bp.ResolvePredicted = 0; bp.ClearReq = 0;
    m_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 1, 0, 0);
    step(0, 0, 1, 32'h100, 1, 0, 0);
    step(1, 32'h100, 1, 32'h100, 1, 1, 0);
    step(1, 32'h100, 1, 32'h100, 0, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 1, 0, 0);
    idle();
    step(0, 0, 1, 32'h300, 0, 0, 0);
    step(1, 32'h104, 1, 32'h104, 1, 0, 0);
    step(1, 32'h104, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 1, 1, 0);
    step(0, 0, 1, 32'h200, 1, 1, 0);
    step(1, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) step(1, 32'h200, 1, 32'h200, 1, 0, i == 5);
    step(1, 32'h200, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      rpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      step(1'($urandom), pc, 1'($urandom), rpc, 1'($urandom), 1'($urandom), $urandom_range(0, 59) == 0);
    end
    while (clear_left > 0) idle();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(i) << 2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) idle();
    @(negedge clk);
    reset = 1'b1;
    #1 check_reset_outputs("midclear");
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 64; i++) step(1, 32'(i) << 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h40, 1, 1, 0);
    step(0, 0, 1, 32'h44, 1, 0, 0);
    step(0, 0, 1, 32'h48, 0, 0, 0);
    idle();
    idle();
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
